alu_issue_stage: RTL and testbench
==================================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port `clock` SHALL be an input, 1 bit wide: the single clock, rising edge.
REQ-003 Port `reset_n` SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-004 Port `in_valid` SHALL be an input, 1 bit wide: decode presents an instruction.
REQ-005 Port `in_ready` SHALL be an output, 1 bit wide: the stage accepts the instruction this cycle.
REQ-006 Port `in_insn` SHALL be an input, 32 bits wide: instruction word (opcode [31:27], rd [26:22], rs [21:17], rt [16:12], shamt [11:7], aluop [6:2], imm [16:0]).
REQ-007 Port `in_pc` SHALL be an input, 32 bits wide: instruction PC.
REQ-008 Ports `in_rs_data` and `in_rt_data` SHALL be inputs, 32 bits wide each: register-file read data.
REQ-009 Ports `xm_valid`, `xm_rd` and `xm_result` SHALL be inputs, 1, 5 and 32 bits wide: X/M writeback candidate.
REQ-010 Ports `mw_valid`, `mw_rd` and `mw_result` SHALL be inputs, 1, 5 and 32 bits wide: M/W writeback candidate.
REQ-011 Port `flush` SHALL be an input, 1 bit wide: squash the held and incoming instruction.
REQ-012 Port `out_valid` SHALL be an output, 1 bit wide: the ALU operands are valid.
REQ-013 Port `out_ready` SHALL be an input, 1 bit wide: the ALU/execute stage consumes this cycle.
REQ-014 Ports `out_operandA` and `out_operandB` SHALL be outputs, 32 bits wide each: ALU data_operandA and data_operandB.
REQ-015 Ports `out_aluop` and `out_shamt` SHALL be outputs, 5 bits wide each: ALU ctrl_ALUopcode and ctrl_shiftamt.
REQ-016 Ports `out_rd` and `out_pc` SHALL be outputs, 5 and 32 bits wide: destination register and PC.

Function
REQ-017 The stage SHALL hold one registered entry, with `in_ready` = !out_valid | out_ready, computed combinationally.
REQ-018 Capture SHALL occur on a rising edge when in_valid & in_ready & !flush; latency SHALL be 1 cycle from input to `out_*`.
REQ-019 When out_valid & out_ready and no capture occurs, `out_valid` SHALL clear on the next edge.
REQ-020 When out_valid & !out_ready (stall), every `out_*` SHALL hold stable.
REQ-021 `flush` SHALL clear `out_valid` on the next edge, SHALL take priority over capture, and SHALL drop the incoming instruction.
REQ-022 For R-type (opcode 00000), the stage SHALL pass `out_aluop` = insn[6:2], `out_shamt` = insn[11:7], operandA = rs, operandB = rt.
REQ-023 For addi (00101), lw (01000) and sw (00111), the stage SHALL force `out_aluop` = 00000 and `out_shamt` = 0, with operandB = imm[16:0] sign-extended to 32 bits.
REQ-024 For any other opcode, the stage SHALL output `out_aluop` = 00000, operandB = rt and `out_rd` = 0.
REQ-025 For forwarding of each source: when xm_valid and xm_rd == src and src != 0, the stage SHALL use xm_result.
REQ-026 Otherwise, when mw_valid and mw_rd == src and src != 0, the stage SHALL use mw_result; otherwise it SHALL use the register-file data.
REQ-027 X/M forwarding SHALL win when both X/M and M/W match.
REQ-028 Forwarding SHALL be resolved at capture time only; a stalled entry SHALL NOT re-forward.

Reset
REQ-029 On reset_n = 0, `out_valid` SHALL be 0 immediately, asynchronously.
REQ-030 On reset_n = 0, all other registered outputs SHALL be 0.
REQ-031 A reset asserted mid-stall SHALL discard the held entry.
REQ-032 The first capture SHALL be possible on the first rising edge after reset_n = 1.

Configuration
REQ-033 With macro ALU_ISSUE_FWD_EN defined, REQ-025 to REQ-028 SHALL apply.
REQ-034 Without ALU_ISSUE_FWD_EN, operands SHALL come from in_rs_data/in_rt_data only, and the xm_*/mw_* ports SHALL remain present but unused.

Structure
REQ-035 Package alu_issue_pkg SHALL hold the opcode constants (R-type, addi, lw, sw), the instruction field bit positions and the ALU opcode ADD = 00000.
REQ-036 Sub-module fwd_mux SHALL perform single-operand source selection, instantiated twice (rs, rt).

Verification
REQ-037 The bench SHALL cover reset-release: R-type add with rs=3 (data 5) and rt=4 (data 7) -> next cycle out_valid=1, A=5, B=7, aluop=00000.
REQ-038 The bench SHALL cover addi with imm=0x1FFFF -> operandB=0xFFFFFFFF, aluop=00000.
REQ-039 The bench SHALL cover xm_rd=3 (xm_result=0x10) and mw_rd=3 (mw_result=0x20) both valid -> operandA=0x10; with rs=0 and xm_rd=0 -> operandA=in_rs_data.
REQ-040 The bench SHALL cover out_ready=0 for 3 cycles with new inputs applied -> in_ready=0, outputs unchanged; out_ready=1 -> next entry captured in the same cycle.
REQ-041 The bench SHALL cover flush together with in_valid during a stall -> out_valid=0 next cycle, with no capture.
REQ-042 The bench SHALL cover reset_n dropped while out_valid=1 between clock edges -> out_valid=0 before the next edge.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// ============================================================================
// Module : alu_issue_pkg
// Brief  : Opcode constants, instruction field positions and shared types
//          for the ALU issue stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_issue_pkg;

  localparam logic [4:0] C_OP_RTYPE = 5'b00000;
  localparam logic [4:0] C_OP_ADDI  = 5'b00101;
  localparam logic [4:0] C_OP_LW    = 5'b01000;
  localparam logic [4:0] C_OP_SW    = 5'b00111;
  localparam logic [4:0] C_ALU_ADD  = 5'b00000;

  localparam int C_OPCODE_HI = 31;
  localparam int C_OPCODE_LO = 27;
  localparam int C_RD_HI     = 26;
  localparam int C_RD_LO     = 22;
  localparam int C_RS_HI     = 21;
  localparam int C_RS_LO     = 17;
  localparam int C_RT_HI     = 16;
  localparam int C_RT_LO     = 12;
  localparam int C_SHAMT_HI  = 11;
  localparam int C_SHAMT_LO  = 7;
  localparam int C_ALUOP_HI  = 6;
  localparam int C_ALUOP_LO  = 2;
  localparam int C_IMM_HI    = 16;
  localparam int C_IMM_LO    = 0;

  typedef enum logic [1:0] {
    INSN_RTYPE = 2'd0,
    INSN_IMM   = 2'd1,
    INSN_OTHER = 2'd2
  } insn_class_e;

  typedef struct packed {
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  aluop;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [31:0] pc;
  } issue_entry_t;

  function automatic insn_class_e classify(input logic [4:0] opcode);
    insn_class_e cls;
    case (opcode)
      C_OP_RTYPE:                   cls = INSN_RTYPE;
      C_OP_ADDI, C_OP_LW, C_OP_SW:  cls = INSN_IMM;
      default:                      cls = INSN_OTHER;
    endcase
    return cls;
  endfunction

  function automatic logic [31:0] sext_imm(input logic [16:0] imm);
    return {{15{imm[16]}}, imm};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_issue_stage_fwd_mux.sv
// ============================================================================
// Module : fwd_mux
// Brief  : Single-operand source select: X/M result, M/W result or register
//          file data. Register 0 is never forwarded; X/M wins over M/W.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_mux #(
  parameter bit FWD_EN = 1'b0
) (
  input  logic [4:0]  src_i,
  input  logic [31:0] rf_data_i,
  input  logic        xm_valid_i,
  input  logic [4:0]  xm_rd_i,
  input  logic [31:0] xm_result_i,
  input  logic        mw_valid_i,
  input  logic [4:0]  mw_rd_i,
  input  logic [31:0] mw_result_i,
  output logic [31:0] operand_o
);

  logic w_xm_hit;
  logic w_mw_hit;

  assign w_xm_hit = FWD_EN && xm_valid_i && (xm_rd_i == src_i) && (src_i != 5'd0);
  assign w_mw_hit = FWD_EN && mw_valid_i && (mw_rd_i == src_i) && (src_i != 5'd0);

  always_comb begin
    operand_o = rf_data_i;
    if (w_xm_hit) begin
      operand_o = xm_result_i;
    end else if (w_mw_hit) begin
      operand_o = mw_result_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module : alu_issue_stage
// Brief  : One-entry registered issue stage feeding the ALU. Decodes operand
//          and control selection; optional operand forwarding is enabled by
//          defining the macro ALU_ISSUE_FWD_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_insn,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic        xm_valid,
  input  logic [4:0]  xm_rd,
  input  logic [31:0] xm_result,
  input  logic        mw_valid,
  input  logic [4:0]  mw_rd,
  input  logic [31:0] mw_result,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operandA,
  output logic [31:0] out_operandB,
  output logic [4:0]  out_aluop,
  output logic [4:0]  out_shamt,
  output logic [4:0]  out_rd,
  output logic [31:0] out_pc
);

`ifdef ALU_ISSUE_FWD_EN
  localparam bit C_FWD_EN = 1'b1;
`else
  localparam bit C_FWD_EN = 1'b0;
`endif

  logic         valid_q, valid_d;
  issue_entry_t entry_q, entry_d;

  logic         w_in_ready;
  logic         w_capture;
  logic [4:0]   w_opcode;
  logic [4:0]   w_rd;
  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic [31:0]  w_fwd_rs;
  logic [31:0]  w_fwd_rt;
  issue_entry_t w_entry;
  logic         unused_insn_bits;

  assign w_opcode = in_insn[C_OPCODE_HI:C_OPCODE_LO];
  assign w_rd     = in_insn[C_RD_HI:C_RD_LO];
  assign w_rs     = in_insn[C_RS_HI:C_RS_LO];
  assign w_rt     = in_insn[C_RT_HI:C_RT_LO];

  assign unused_insn_bits = ^in_insn[1:0];

  fwd_mux #(.FWD_EN(C_FWD_EN)) u_fwd_rs (
    .src_i       (w_rs),
    .rf_data_i   (in_rs_data),
    .xm_valid_i  (xm_valid),
    .xm_rd_i     (xm_rd),
    .xm_result_i (xm_result),
    .mw_valid_i  (mw_valid),
    .mw_rd_i     (mw_rd),
    .mw_result_i (mw_result),
    .operand_o   (w_fwd_rs)
  );

  fwd_mux #(.FWD_EN(C_FWD_EN)) u_fwd_rt (
    .src_i       (w_rt),
    .rf_data_i   (in_rt_data),
    .xm_valid_i  (xm_valid),
    .xm_rd_i     (xm_rd),
    .xm_result_i (xm_result),
    .mw_valid_i  (mw_valid),
    .mw_rd_i     (mw_rd),
    .mw_result_i (mw_result),
    .operand_o   (w_fwd_rt)
  );

  // Unrecognised opcodes issue as a harmless ADD with no destination.
  always_comb begin
    w_entry           = '0;
    w_entry.operand_a = w_fwd_rs;
    w_entry.operand_b = w_fwd_rt;
    w_entry.aluop     = C_ALU_ADD;
    w_entry.shamt     = 5'd0;
    w_entry.rd        = 5'd0;
    w_entry.pc        = in_pc;
    case (classify(w_opcode))
      INSN_RTYPE: begin
        w_entry.aluop = in_insn[C_ALUOP_HI:C_ALUOP_LO];
        w_entry.shamt = in_insn[C_SHAMT_HI:C_SHAMT_LO];
        w_entry.rd    = w_rd;
      end
      INSN_IMM: begin
        w_entry.operand_b = sext_imm(in_insn[C_IMM_HI:C_IMM_LO]);
        w_entry.rd        = w_rd;
      end
      default: begin
      end
    endcase
  end

  assign w_in_ready = !valid_q || out_ready;
  assign w_capture  = in_valid && w_in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (w_capture) begin
      valid_d = 1'b1;
      entry_d = w_entry;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = valid_q;
  assign out_operandA = entry_q.operand_a;
  assign out_operandB = entry_q.operand_b;
  assign out_aluop    = entry_q.aluop;
  assign out_shamt    = entry_q.shamt;
  assign out_rd       = entry_q.rd;
  assign out_pc       = entry_q.pc;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module : tb_alu_issue_stage
// Brief  : Scoreboard bench for alu_issue_stage; forwarding expectations
//          follow the ALU_ISSUE_FWD_EN macro.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

`ifdef ALU_ISSUE_FWD_EN
  localparam bit C_FWD = 1'b1;
`else
  localparam bit C_FWD = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  aluop;
    logic [4:0]  shamt;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_insn;
  logic [31:0] in_pc;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic        xm_valid;
  logic [4:0]  xm_rd;
  logic [31:0] xm_result;
  logic        mw_valid;
  logic [4:0]  mw_rd;
  logic [31:0] mw_result;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operandA;
  logic [31:0] out_operandB;
  logic [4:0]  out_aluop;
  logic [4:0]  out_shamt;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  alu_issue_stage dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_insn      (in_insn),
    .in_pc        (in_pc),
    .in_rs_data   (in_rs_data),
    .in_rt_data   (in_rt_data),
    .xm_valid     (xm_valid),
    .xm_rd        (xm_rd),
    .xm_result    (xm_result),
    .mw_valid     (mw_valid),
    .mw_rd        (mw_rd),
    .mw_result    (mw_result),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_operandA (out_operandA),
    .out_operandB (out_operandB),
    .out_aluop    (out_aluop),
    .out_shamt    (out_shamt),
    .out_rd       (out_rd),
    .out_pc       (out_pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] shamt, input logic [4:0] aluop);
    return {op, rd, rs, rt, shamt, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] src, input logic [31:0] rf);
    if (C_FWD && src != 5'd0 && xm_valid && xm_rd == src) return xm_result;
    if (C_FWD && src != 5'd0 && mw_valid && mw_rd == src) return mw_result;
    return rf;
  endfunction

  function automatic exp_t model(input logic [31:0] insn, input logic [31:0] pc,
                                 input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    logic [4:0] op;
    op      = insn[31:27];
    e.a     = src_val(insn[21:17], rsd);
    e.pc    = pc;
    e.aluop = 5'd0;
    e.shamt = 5'd0;
    if (op == 5'b00000) begin
      e.b     = src_val(insn[16:12], rtd);
      e.aluop = insn[6:2];
      e.shamt = insn[11:7];
      e.rd    = insn[26:22];
    end else if (op == 5'b00101 || op == 5'b01000 || op == 5'b00111) begin
      e.b  = {{15{insn[16]}}, insn[16:0]};
      e.rd = insn[26:22];
    end else begin
      e.b  = src_val(insn[16:12], rtd);
      e.rd = 5'd0;
    end
    return e;
  endfunction

  // Retire on consumption (or drop on flush), then record any capture.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n) begin
      if (out_valid && (out_ready || flush)) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (out_ready) begin
            chk("opA",   out_operandA, e.a);
            chk("opB",   out_operandB, e.b);
            chk("aluop", 32'(out_aluop), 32'(e.aluop));
            chk("shamt", 32'(out_shamt), 32'(e.shamt));
            chk("rd",    32'(out_rd),    32'(e.rd));
            chk("pc",    out_pc,         e.pc);
          end
        end
      end
      if (in_valid && in_ready && !flush) sb.push_back(model(in_insn, in_pc, in_rs_data, in_rt_data));
    end
  end

  task automatic send(input logic [31:0] insn, input logic [31:0] pc,
                      input logic [31:0] rsd, input logic [31:0] rtd);
    bit ok;
    in_insn    = insn;
    in_pc      = pc;
    in_rs_data = rsd;
    in_rt_data = rtd;
    in_valid   = 1'b1;
    ok         = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    chk("watchdog", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t xe;
    reset_n = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0;
    in_rs_data = '0; in_rt_data = '0; xm_valid = 1'b0; xm_rd = '0; xm_result = '0;
    mw_valid = 1'b0; mw_rd = '0; mw_result = '0; flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(negedge clock);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_opA",   out_operandA,   32'd0);
    chk("rst_opB",   out_operandB,   32'd0);
    chk("rst_pc",    out_pc,         32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    send(mk_r(5'b00000, 5'd1, 5'd3, 5'd4, 5'd0, 5'd0), 32'h100, 32'd5, 32'd7);
    chk("lat_valid", 32'(out_valid), 32'd1);
    send(mk_r(5'b00000, 5'd7, 5'd1, 5'd2, 5'd5, 5'd1), 32'h104, 32'hAAAA0000, 32'h00005555);
    send(mk_i(5'b00101, 5'd2, 5'd3, 17'h1FFFF), 32'h108, 32'd11, 32'd22);
    send(mk_i(5'b01000, 5'd4, 5'd5, 17'h00010), 32'h10C, 32'h1000, 32'd0);
    send(mk_i(5'b00111, 5'd6, 5'd7, 17'h10000), 32'h110, 32'h2000, 32'h3);
    send(mk_r(5'b00010, 5'd9, 5'd8, 5'd6, 5'd3, 5'd7), 32'h114, 32'h44, 32'h99);

    xm_valid = 1'b1; xm_rd = 5'd3; xm_result = 32'h10;
    mw_valid = 1'b1; mw_rd = 5'd3; mw_result = 32'h20;
    send(mk_r(5'b00000, 5'd1, 5'd3, 5'd9, 5'd0, 5'd0), 32'h118, 32'h55, 32'h66);
    xm_rd = 5'd5;
    send(mk_r(5'b00000, 5'd1, 5'd3, 5'd5, 5'd0, 5'd2), 32'h11C, 32'h55, 32'h66);
    xm_rd = 5'd0; mw_rd = 5'd0;
    send(mk_r(5'b00000, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0), 32'h120, 32'h77, 32'h88);
    xm_valid = 1'b0; mw_valid = 1'b0;
    idle(2);

    // Stall with a changing forwarding source: the held entry must not move.
    out_ready = 1'b0;
    xm_valid = 1'b1; xm_rd = 5'd6; xm_result = 32'h1234;
    xe = model(mk_r(5'b00000, 5'd2, 5'd6, 5'd7, 5'd1, 5'd3), 32'h200, 32'h600, 32'h700);
    send(mk_r(5'b00000, 5'd2, 5'd6, 5'd7, 5'd1, 5'd3), 32'h200, 32'h600, 32'h700);
    in_insn = mk_r(5'b00000, 5'd3, 5'd6, 5'd6, 5'd0, 5'd4);
    in_pc = 32'h204; in_rs_data = 32'hBEEF; in_rt_data = 32'hCAFE;
    xm_result = 32'hDEAD; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("stall_ready", 32'(in_ready),  32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_opA",   out_operandA,   xe.a);
      chk("stall_opB",   out_operandB,   xe.b);
      chk("stall_pc",    out_pc,         xe.pc);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0; xm_valid = 1'b0;
    idle(2);

    // Flush during a stall drops both the held and the incoming entry.
    out_ready = 1'b0;
    send(mk_r(5'b00000, 5'd4, 5'd1, 5'd2, 5'd0, 5'd0), 32'h300, 32'h1, 32'h2);
    in_insn = mk_r(5'b00000, 5'd5, 5'd1, 5'd2, 5'd0, 5'd0);
    in_pc = 32'h304; in_valid = 1'b1; flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready),  32'd1);
    chk("flush_sb",    32'(sb.size()), 32'd0);
    #1;
    out_ready = 1'b1;
    idle(1);

    // Asynchronous reset between edges while an entry is stalled.
    out_ready = 1'b0;
    send(mk_r(5'b00000, 5'd6, 5'd1, 5'd2, 5'd0, 5'd0), 32'h400, 32'h9, 32'hA);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_opA",   out_operandA,   32'd0);
    chk("arst_pc",    out_pc,         32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    send(mk_r(5'b00000, 5'd8, 5'd2, 5'd3, 5'd2, 5'd6), 32'h500, 32'h31, 32'h32);
    idle(3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
